// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table: 2-bit saturating counters plus a target buffer.
// Define BP_TAG_CHECK_EN to add per-entry tags so that aliasing PCs miss instead of sharing an entry.
module branch_predictor_bht #(
   parameter int IDX_W = 6,
   parameter int PC_W  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PC_W-1:0] if_pc,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target,
   input  logic            ex_valid,
   input  logic [PC_W-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [PC_W-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [PC_W-1:0] ex_pred_target,
   output logic            mispredict,
   output logic [PC_W-1:0] redirect_pc,
   output logic            stat_update_en,
   output logic            stat_mispredict
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [ENTRIES-1:0] valid_q;
   logic [1:0]         ctr_q    [ENTRIES];
   logic [PC_W-1:0]    target_q [ENTRIES];
`ifdef BP_TAG_CHECK_EN
   localparam int TAG_W = PC_W - IDX_W - 2;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
`endif

   logic [IDX_W-1:0] ifIdx;
   logic [IDX_W-1:0] exIdx;
   logic             ifHit;
   logic             exHit;
   logic [PC_W-1:0]  ifPcPlus4;
   logic [PC_W-1:0]  exPcPlus4;
   logic             entryWe;
   logic [1:0]       ctr_d;
   logic [PC_W-1:0]  target_d;
   logic             statUpdate_q;
   logic             statMispredict_q;

   assign ifIdx     = if_pc[IDX_W+1:2];
   assign exIdx     = ex_pc[IDX_W+1:2];
   assign ifPcPlus4 = if_pc + PC_W'(4);
   assign exPcPlus4 = ex_pc + PC_W'(4);

`ifdef BP_TAG_CHECK_EN
   assign ifHit = valid_q[ifIdx] && (tag_q[ifIdx] == if_pc[PC_W-1:IDX_W+2]);
   assign exHit = valid_q[exIdx] && (tag_q[exIdx] == ex_pc[PC_W-1:IDX_W+2]);
`else
   assign ifHit = valid_q[ifIdx];
   assign exHit = valid_q[exIdx];
`endif

   // Lookup reads the stored entry directly, so a same-cycle update is not bypassed.
   assign pred_taken  = ifHit && ctr_q[ifIdx][1];
   assign pred_target = pred_taken ? target_q[ifIdx] : ifPcPlus4;

   assign mispredict  = ex_valid &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target)));
   assign redirect_pc = ex_taken ? ex_target : exPcPlus4;

   // Training: a hit always rewrites valid/tag with identical values, which lets
   // allocation and hit updates share a single write port.
   always_comb begin
      entryWe  = 1'b0;
      ctr_d    = ctr_q[exIdx];
      target_d = target_q[exIdx];
      if (ex_valid) begin
         if (exHit) begin
            entryWe = 1'b1;
            if (ex_taken) begin
               ctr_d    = (ctr_q[exIdx] == 2'b11) ? 2'b11 : ctr_q[exIdx] + 2'd1;
               target_d = ex_target;
            end else begin
               ctr_d    = (ctr_q[exIdx] == 2'b00) ? 2'b00 : ctr_q[exIdx] - 2'd1;
            end
         end else if (ex_taken) begin
            entryWe  = 1'b1;
            ctr_d    = 2'b10;
            target_d = ex_target;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i]    <= 2'b01;
            target_q[i] <= '0;
`ifdef BP_TAG_CHECK_EN
            tag_q[i]    <= '0;
`endif
         end
      end else if (entryWe) begin
         valid_q[exIdx]  <= 1'b1;
         ctr_q[exIdx]    <= ctr_d;
         target_q[exIdx] <= target_d;
`ifdef BP_TAG_CHECK_EN
         tag_q[exIdx]    <= ex_pc[PC_W-1:IDX_W+2];
`endif
      end
   end

   // One-cycle delayed resolved-branch event stream for the statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         statUpdate_q     <= 1'b0;
         statMispredict_q <= 1'b0;
      end else begin
         statUpdate_q     <= ex_valid;
         statMispredict_q <= mispredict;
      end
   end

   assign stat_update_en  = statUpdate_q;
   assign stat_mispredict = statMispredict_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: a driver queues hand-computed expectations,
// a negedge monitor pops and compares lookup, flush and statistics outputs.
module tb_branch_predictor_bht;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        stat_update_en;
   logic        stat_mispredict;

   typedef struct {
      logic        predTaken;
      logic [31:0] predTarget;
      logic        chkMisp;
      logic        chkRedir;
      logic        misp;
      logic [31:0] redir;
   } lookExp_t;

   typedef struct {
      int   due;
      logic misp;
   } statExp_t;

   lookExp_t lookQ[$];
   statExp_t statQ[$];
   int       cyc;
   int       compared;
   int       mismatched;

   branch_predictor_bht #(.IDX_W(6), .PC_W(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .if_pc           (if_pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .ex_valid        (ex_valid),
      .ex_pc           (ex_pc),
      .ex_taken        (ex_taken),
      .ex_target       (ex_target),
      .ex_pred_taken   (ex_pred_taken),
      .ex_pred_target  (ex_pred_target),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc),
      .stat_update_en  (stat_update_en),
      .stat_mispredict (stat_mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: statistics pulses are matched against the cycle they are due in,
   // lookup/flush outputs against whatever the driver queued for this cycle.
   always @(negedge clk) begin
      logic expPulse;
      expPulse = (statQ.size() > 0) && (statQ[0].due == cyc);
      checkOutput("stat_update_en", 32'(stat_update_en), 32'(expPulse));
      if (expPulse) begin
         statExp_t s;
         s = statQ.pop_front();
         checkOutput("stat_mispredict", 32'(stat_mispredict), 32'(s.misp));
      end
      if (lookQ.size() > 0) begin
         lookExp_t e;
         e = lookQ.pop_front();
         checkOutput("pred_taken", 32'(pred_taken), 32'(e.predTaken));
         checkOutput("pred_target", pred_target, e.predTarget);
         if (e.chkMisp) checkOutput("mispredict", 32'(mispredict), 32'(e.misp));
         if (e.chkRedir) checkOutput("redirect_pc", redirect_pc, e.redir);
      end
   end

   task automatic applyStimulus(
      input logic        rstN,
      input logic [31:0] ifPc,
      input logic        exV,
      input logic [31:0] exPc,
      input logic        exT,
      input logic [31:0] exTgt,
      input logic        exPT,
      input logic [31:0] exPTgt,
      input logic        expPT,
      input logic [31:0] expPTgt,
      input logic        chkM,
      input logic        expM,
      input logic [31:0] expRedir
   );
      lookExp_t e;
      statExp_t s;
      @(posedge clk);
      #1;
      rst_n          = rstN;
      if_pc          = ifPc;
      ex_valid       = exV;
      ex_pc          = exPc;
      ex_taken       = exT;
      ex_target      = exTgt;
      ex_pred_taken  = exPT;
      ex_pred_target = exPTgt;
      e.predTaken  = expPT;
      e.predTarget = expPTgt;
      e.chkMisp    = chkM;
      e.chkRedir   = chkM && exV;
      e.misp       = expM;
      e.redir      = expRedir;
      lookQ.push_back(e);
      if (exV && rstN) begin
         s.due  = cyc + 1;
         s.misp = expM;
         statQ.push_back(s);
      end
   endtask

   task automatic idleLookup(input logic [31:0] ifPc, input logic expPT, input logic [31:0] expPTgt);
      applyStimulus(1'b1, ifPc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    expPT, expPTgt, 1'b1, 1'b0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        aliasPT;
      logic [31:0] aliasTgt;
      cyc            = 0;
      compared       = 0;
      mismatched     = 0;
      rst_n          = 1'b0;
      if_pc          = 32'h100;
      ex_valid       = 1'b0;
      ex_pc          = 32'h0;
      ex_taken       = 1'b0;
      ex_target      = 32'h0;
      ex_pred_taken  = 1'b0;
      ex_pred_target = 32'h0;

      // Held in reset: table empty, no prediction
      applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b1, 1'b0, 32'h0);

      // A: allocate 0x100 -> 0x80 (lookup still sees the old empty entry)
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 1'b1, 32'h80);
      idleLookup(32'h100, 1'b1, 32'h80);
      // C/D/E: three not-taken resolves, counter 10 -> 01 -> 00 -> 00
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b1, 32'h104);
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 1'b0, 32'h104);
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 1'b0, 32'h104);
      idleLookup(32'h100, 1'b0, 32'h104);
      // G: taken on hit increments 00 -> 01, still predicts not-taken
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 1'b1, 32'h80);
      idleLookup(32'h100, 1'b0, 32'h104);
      // I/J back-to-back: 01 -> 10 -> 11, J also has a wrong target
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 1'b1, 32'h80);
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 1'b1, 32'h90);
      // K: correct prediction, counter saturates at 11
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h90, 1'b1, 32'h90, 1'b1, 1'b0, 32'h90);
      // L: not-taken mispredict, 11 -> 10
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h90, 1'b1, 32'h90, 1'b1, 32'h90, 1'b1, 1'b1, 32'h104);
      idleLookup(32'h100, 1'b1, 32'h90);

      // Alias of 0x100 in the same index
`ifdef BP_TAG_CHECK_EN
      aliasPT  = 1'b0;
      aliasTgt = 32'h204;
`else
      aliasPT  = 1'b1;
      aliasTgt = 32'h90;
`endif
      idleLookup(32'h200, aliasPT, aliasTgt);

      // Not-taken miss must not allocate
      applyStimulus(1'b1, 32'h10C, 1'b1, 32'h10C, 1'b0, 32'h500, 1'b0, 32'h110, 1'b0, 32'h110, 1'b1, 1'b0, 32'h110);
      idleLookup(32'h10C, 1'b0, 32'h110);
      // PC+4 wraps to zero
      applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      idleLookup(32'h100, 1'b1, 32'h90);

      // Mid-stream reset with a branch resolving: table clears, update and stat pulse lost
      applyStimulus(1'b0, 32'h100, 1'b1, 32'h14, 1'b1, 32'h40, 1'b0, 32'h18, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0);
      idleLookup(32'h14, 1'b0, 32'h18);
      idleLookup(32'h100, 1'b0, 32'h104);

      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pending_stat_pulses", 32'(statQ.size()), 32'h0);
      checkOutput("pending_lookups", 32'(lookQ.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
